// File: rtl/seq_run_ctrl.sv
// Run controller for the 0->5->7->6->3->2 sequence: start/stop/done handshake around a step-counted run.
// Optional `SEQ_LOAD_CHECK_EN rejects loads of the illegal codes 1 and 4 and pulses err.
module seq_run_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] step_cnt,
  input  logic             stop,
  input  logic             load,
  input  logic [2:0]       load_val,
  output logic [2:0]       q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_left,
  output logic             err
);

  // Handshake: start is accepted only in IDLE; stop only in RUN; done pulses for the single DONE cycle.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [2:0]       q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_ok;

  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'd0:    next_code = 3'd5;
      3'd5:    next_code = 3'd7;
      3'd7:    next_code = 3'd6;
      3'd6:    next_code = 3'd3;
      3'd3:    next_code = 3'd2;
      default: next_code = 3'd0;  // 2 wraps to 0; illegal 1 and 4 recover to 0
    endcase
  endfunction

`ifdef SEQ_LOAD_CHECK_EN
  logic err_q, err_d;
  assign load_ok = (load_val != 3'd1) && (load_val != 3'd4);
  assign err     = err_q;
`else
  assign load_ok = 1'b1;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
`ifdef SEQ_LOAD_CHECK_EN
    err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (load) begin
          if (load_ok) q_d = load_val;
`ifdef SEQ_LOAD_CHECK_EN
          else err_d = 1'b1;
`endif
        end
        if (start) begin
          if (step_cnt != '0) begin
            cnt_d   = step_cnt;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_DONE;
        end else begin
          q_d = next_code(q_q);
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= 3'd0;
      cnt_q   <= '0;
`ifdef SEQ_LOAD_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
`ifdef SEQ_LOAD_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign q        = q_q;
  assign cnt_left = cnt_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_run_ctrl.sv
// Self-checking bench for seq_run_ctrl: expected output vectors are queued per driven cycle and compared after the edge.
module tb_seq_run_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] step_cnt;
  logic       stop;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] q;
  logic       busy;
  logic       done;
  logic [7:0] cnt_left;
  logic       err;

  seq_run_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .step_cnt(step_cnt), .stop(stop),
    .load(load), .load_val(load_val), .q(q), .busy(busy), .done(done),
    .cnt_left(cnt_left), .err(err)
  );

  always #5 clk = ~clk;

  // {q, busy, done, cnt_left, err}
  logic [13:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  cur_q;
  logic [7:0]  cur_cnt;

  function automatic logic [13:0] pack(input logic [2:0] pq, input logic pb, input logic pd,
                                       input logic [7:0] pc, input logic pe);
    pack = {pq, pb, pd, pc, pe};
  endfunction

  function automatic logic [2:0] seq_next(input logic [2:0] c);
    logic [2:0] order [6];
    order = '{3'd0, 3'd5, 3'd7, 3'd6, 3'd3, 3'd2};
    seq_next = 3'd0;
    for (int i = 0; i < 6; i++)
      if (order[i] == c) seq_next = order[(i + 1) % 6];
  endfunction

  task automatic drive(input logic r, input logic st, input logic [7:0] sc, input logic sp,
                       input logic ld, input logic [2:0] lv);
    rst = r; start = st; step_cnt = sc; stop = sp; load = ld; load_val = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] got, ex;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(pack(3'd0, 1'b0, 1'b0, 8'd0, 1'b0));
      drive(c < 2, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0);
      got = {q, busy, done, cnt_left, err};
      ex  = exp_q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL reset cyc%0d: got q=%0d busy=%b done=%b cnt=%0d err=%b, expected q=%0d busy=%b done=%b cnt=%0d err=%b",
                 c, got[13:11], got[10], got[9], got[8:1], got[0], ex[13:11], ex[10], ex[9], ex[8:1], ex[0]);
      end
    end
    cur_q = 3'd0; cur_cnt = 8'd0;
  endtask

  // One run from start to the IDLE cycle after DONE; stop_at=i aborts on the i-th RUN cycle (0 = never).
  // noise drives start/load with random values whenever they must be ignored.
  task automatic test_run(input string name, input int n, input int stop_at, input logic ld,
                          input logic [2:0] lv, input logic noise);
    int          phase, i, c;
    logic        st, sp, l, e_busy, e_done, e_err;
    logic [7:0]  sc;
    logic [2:0]  v;
    logic [13:0] got, ex;
    phase = 0; i = 0; c = 0;
    while (phase != 3) begin
      st = 1'b0; sc = 8'd0; sp = 1'b0; l = 1'b0; v = 3'd0; e_err = 1'b0;
      e_busy = 1'b0; e_done = 1'b0;
      if (noise) begin
        st = 1'b1; sc = 8'($urandom_range(0, 255)); l = 1'b1; v = 3'($urandom_range(0, 7));
      end
      case (phase)
        0: begin
          st = 1'b1; sc = 8'(n); l = ld; v = lv; sp = noise;
          if (ld) begin
`ifdef SEQ_LOAD_CHECK_EN
            if (lv == 3'd1 || lv == 3'd4) e_err = 1'b1;
            else cur_q = lv;
`else
            cur_q = lv;
`endif
          end
          if (n == 0) begin
            e_done = 1'b1; phase = 2;
          end else begin
            cur_cnt = 8'(n); e_busy = 1'b1; phase = 1;
          end
        end
        1: begin
          i++;
          e_busy = 1'b1;
          if (i == stop_at) begin
            sp = 1'b1; e_busy = 1'b0; e_done = 1'b1; phase = 2;
          end else begin
            cur_q = seq_next(cur_q);
            cur_cnt = cur_cnt - 8'd1;
            if (cur_cnt == 8'd0) begin
              e_busy = 1'b0; e_done = 1'b1; phase = 2;
            end
          end
        end
        default: phase = 3;
      endcase
      exp_q.push_back(pack(cur_q, e_busy, e_done, cur_cnt, e_err));
      drive(1'b0, st, sc, sp, l, v);
      got = {q, busy, done, cnt_left, err};
      ex  = exp_q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL %s cyc%0d: got q=%0d busy=%b done=%b cnt=%0d err=%b, expected q=%0d busy=%b done=%b cnt=%0d err=%b",
                 name, c, got[13:11], got[10], got[9], got[8:1], got[0], ex[13:11], ex[10], ex[9], ex[8:1], ex[0]);
      end
      c++;
    end
  endtask

  task automatic test_load_illegal();
    logic [13:0] got, ex;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
`ifdef SEQ_LOAD_CHECK_EN
        exp_q.push_back(pack(cur_q, 1'b0, 1'b0, cur_cnt, 1'b1));
`else
        cur_q = 3'd4;
        exp_q.push_back(pack(cur_q, 1'b0, 1'b0, cur_cnt, 1'b0));
`endif
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b1, 3'd4);
      end else begin
        exp_q.push_back(pack(cur_q, 1'b0, 1'b0, cur_cnt, 1'b0));
        drive(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 3'd0);
      end
      got = {q, busy, done, cnt_left, err};
      ex  = exp_q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL load_illegal cyc%0d: got q=%0d busy=%b done=%b cnt=%0d err=%b, expected q=%0d busy=%b done=%b cnt=%0d err=%b",
                 c, got[13:11], got[10], got[9], got[8:1], got[0], ex[13:11], ex[10], ex[9], ex[8:1], ex[0]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [13:0] got, ex;
    drive(1'b0, 1'b1, 8'd5, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0);
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0);
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back(pack(3'd0, 1'b0, 1'b0, 8'd0, 1'b0));
      drive(c == 0, 1'b0, 8'd0, 1'b0, 1'b0, 3'd0);
      got = {q, busy, done, cnt_left, err};
      ex  = exp_q.pop_front();
      n_checks++;
      if (got !== ex) begin
        n_fail++;
        $display("FAIL reset_midrun cyc%0d: got q=%0d busy=%b done=%b cnt=%0d err=%b, expected q=%0d busy=%b done=%b cnt=%0d err=%b",
                 c, got[13:11], got[10], got[9], got[8:1], got[0], ex[13:11], ex[10], ex[9], ex[8:1], ex[0]);
      end
    end
    cur_q = 3'd0; cur_cnt = 8'd0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_cnt = 8'd0; stop = 1'b0; load = 1'b0; load_val = 3'd0;
    test_reset();
    test_run("run3", 3, 0, 1'b0, 3'd0, 1'b0);
    test_run("wrap7", 7, 0, 1'b1, 3'd0, 1'b0);
    test_run("abort", 10, 3, 1'b1, 3'd0, 1'b1);
    test_run("load_start", 2, 0, 1'b1, 3'd3, 1'b0);
    test_load_illegal();
    test_run("illegal_adv", 1, 0, 1'b0, 3'd0, 1'b0);
    test_run("illegal_load_start", 2, 0, 1'b1, 3'd1, 1'b0);
    test_reset_midrun();
    test_run("zero_steps", 0, 0, 1'b0, 3'd0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      int rn;
      rn = $urandom_range(0, 12);
      test_run("random", rn, $urandom_range(0, rn), 1'b1, 3'($urandom_range(0, 7)), 1'b1);
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
